addsub_fu: RTL and testbench

- Parametrised, pipelined, fracturable add/subtract functional unit for the CGRA tile datapath.
- Successor to the fixed 4x16b/2x32b/1x64b adder FU. Adds:
  - generic lane count and width;
  - subtract;
  - signed saturation;
  - carry and overflow flags;
  - a start/ack FSM with a fixed 3-cycle latency.
- Configured per operation by the tile config word. Routes dest_info through to the tile switch.

---
 rtl/addsub_fu_pkg.sv | 34 +++
 rtl/addsub_lane.sv | 23 ++
 rtl/addsub_fu.sv | 194 +++++++++++++++++++
 tb/tb_addsub_fu.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_fu_pkg.sv
// Shared types and constants for the fracturable add/subtract functional unit.
// Holds the FSM states, segment-mode encodings, config field positions and the segment-size lookup.
package addsub_fu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [1:0] MODE_1L  = 2'd0;
    localparam logic [1:0] MODE_2L  = 2'd1;
    localparam logic [1:0] MODE_4L  = 2'd2;
    localparam logic [1:0] MODE_ALL = 2'd3;

    localparam int CFG_MODE_LSB = 0;
    localparam int CFG_MODE_MSB = 1;
    localparam int CFG_SUB_BIT  = 2;
    localparam int CFG_SAT_BIT  = 3;
    localparam int CFG_DEST_LSB = 4;
    localparam int CFG_DEST_MSB = 7;

    // Lanes per segment; 0 flags a mode this lane count cannot build.
    function automatic int seg_lanes(input logic [1:0] mode, input int num_lanes);
        case (mode)
            MODE_1L:  return 1;
            MODE_2L:  return 2;
            MODE_4L:  return (num_lanes >= 8) ? 4 : 0;
            default:  return num_lanes;
        endcase
    endfunction

endpackage

// File: rtl/addsub_lane.sv
// One width-bit adder slice with carry-in; combinational, no handshake.
// Exposes the carry into the MSB so the parent can derive signed overflow.
module addsub_lane
    import addsub_fu_pkg::*;
#(
    parameter int width = 16
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             cin_i,
    output logic [width-1:0] sum_o,
    output logic             cout_o,
    output logic             msb_cin_o
);

    logic [width:0] full;

    assign full      = {1'b0, a_i} + {1'b0, b_i} + {{width{1'b0}}, cin_i};
    assign sum_o     = full[width-1:0];
    assign cout_o    = full[width];
    assign msb_cin_o = a_i[width-1] ^ b_i[width-1] ^ sum_o[width-1];

endmodule

// File: rtl/addsub_fu.sv
// Fracturable, saturating add/subtract FU: lanes join into segments chosen by the config mode.
// Fixed 3-edge latency from the on_off sample to ack; ack holds until on_off drops, no retrigger.
module addsub_fu
    import addsub_fu_pkg::*;
#(
    parameter int width     = 16,
    parameter int num_lanes = 4,
    parameter int cfg_width = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                on_off,
    input  logic [2*num_lanes-1:0][width-1:0]   inputs,
    input  logic [cfg_width-1:0]                config_in,
    output logic [num_lanes-1:0][width-1:0]     outputs,
    output logic [3:0]                          dest_info,
    output logic [num_lanes-1:0]                carry_out,
    output logic [num_lanes-1:0]                overflow,
    output logic                                cfg_err,
    output logic                                ack
);

    localparam logic [width-1:0] LANE_ONE = width'(1);

    state_e                             state_q;
    logic [num_lanes-1:0][width-1:0]    a_q, b_q;
    logic [1:0]                         mode_q;
    logic                               sub_q, sat_q;
    logic [3:0]                         dest_q;

    logic [num_lanes-1:0][width-1:0]    s1_sum_q;
    logic [num_lanes-1:0]               s1_c_q, s1_f_q, s1_x_q;

    logic [num_lanes-1:0][width-1:0]    outputs_q;
    logic [num_lanes-1:0]               carry_q, ovf_q;
    logic [3:0]                         dest_info_q;
    logic                               cfg_err_q, ack_q;

    logic [num_lanes-1:0][width-1:0]    lane_sum;
    logic [num_lanes-1:0]               lane_cout, lane_msbc, lane_f, lane_x;

    logic unused_cfg;
    assign unused_cfg = ^config_in[cfg_width-1:CFG_DEST_MSB+1];

    // Every lane starts with carry-in = sub; lane_f marks lanes whose carry-out
    // would flip if the real carry-in from the lane below differs from that guess.
    for (genvar g = 0; g < num_lanes; g++) begin : g_lane
        addsub_lane #(.width(width)) u_lane (
            .a_i       (a_q[g]),
            .b_i       (b_q[g] ^ {width{sub_q}}),
            .cin_i     (sub_q),
            .sum_o     (lane_sum[g]),
            .cout_o    (lane_cout[g]),
            .msb_cin_o (lane_msbc[g])
        );
        assign lane_f[g] = sub_q ? (lane_cout[g] && (lane_sum[g] == '0))
                                 : (lane_sum[g] == '1);
        assign lane_x[g] = lane_msbc[g] ^ lane_sum[g][width-1];
    end

    logic [num_lanes-1:0][width-1:0]    res_d;
    logic [num_lanes-1:0]               carry_d, ovf_d, raw_msb;
    logic                               cfg_err_d;
    logic                               c_in, c_out, ovl;
    logic [width-1:0]                   fix_sum;
    int                                 seg_n, mask, top;

    always_comb begin
        res_d     = '0;
        carry_d   = '0;
        ovf_d     = '0;
        raw_msb   = '0;
        cfg_err_d = 1'b0;
        c_in      = sub_q;
        c_out     = 1'b0;
        ovl       = 1'b0;
        fix_sum   = '0;
        top       = 0;
        seg_n     = seg_lanes(mode_q, num_lanes);
        mask      = (seg_n > 0) ? seg_n - 1 : 0;
        if (seg_n == 0) begin
            cfg_err_d = 1'b1;
        end else begin
            for (int k = 0; k < num_lanes; k++) begin
                if ((k & mask) == 0) begin
                    c_in = sub_q;
                end
                // Correct the stage-1 sum by the difference between the true and guessed carry-in.
                if (c_in == sub_q) begin
                    fix_sum = s1_sum_q[k];
                end else if (sub_q) begin
                    fix_sum = s1_sum_q[k] - LANE_ONE;
                end else begin
                    fix_sum = s1_sum_q[k] + LANE_ONE;
                end
                if (sub_q) begin
                    c_out = s1_c_q[k] & ~(s1_f_q[k] & ~c_in);
                end else begin
                    c_out = s1_c_q[k] | (s1_f_q[k] & c_in);
                end
                ovl        = s1_x_q[k] ^ fix_sum[width-1] ^ c_out;
                res_d[k]   = fix_sum;
                raw_msb[k] = fix_sum[width-1];
                if ((k & mask) == mask) begin
                    carry_d[k] = c_out;
                    ovf_d[k]   = ovl;
                end
                c_in = c_out;
            end
            if (sat_q) begin
                // A wrapped negative result means the true value was too positive, and vice versa.
                for (int k = 0; k < num_lanes; k++) begin
                    top = k | mask;
                    if (ovf_d[top]) begin
                        if (k == top) begin
                            res_d[k] = {~raw_msb[top], {(width-1){raw_msb[top]}}};
                        end else begin
                            res_d[k] = {width{raw_msb[top]}};
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= MODE_1L;
            sub_q       <= 1'b0;
            sat_q       <= 1'b0;
            dest_q      <= '0;
            s1_sum_q    <= '0;
            s1_c_q      <= '0;
            s1_f_q      <= '0;
            s1_x_q      <= '0;
            outputs_q   <= '0;
            carry_q     <= '0;
            ovf_q       <= '0;
            dest_info_q <= '0;
            cfg_err_q   <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (on_off) begin
                        for (int k = 0; k < num_lanes; k++) begin
                            a_q[k] <= inputs[2*k];
                            b_q[k] <= inputs[2*k+1];
                        end
                        mode_q  <= config_in[CFG_MODE_MSB:CFG_MODE_LSB];
                        sub_q   <= config_in[CFG_SUB_BIT];
                        sat_q   <= config_in[CFG_SAT_BIT];
                        dest_q  <= config_in[CFG_DEST_MSB:CFG_DEST_LSB];
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    s1_sum_q <= lane_sum;
                    s1_c_q   <= lane_cout;
                    s1_f_q   <= lane_f;
                    s1_x_q   <= lane_x;
                    state_q  <= RESOLVE;
                end
                RESOLVE: begin
                    outputs_q   <= res_d;
                    carry_q     <= carry_d;
                    ovf_q       <= ovf_d;
                    dest_info_q <= dest_q;
                    cfg_err_q   <= cfg_err_d;
                    ack_q       <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (!on_off) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign outputs   = outputs_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign dest_info = dest_info_q;
    assign cfg_err   = cfg_err_q;
    assign ack       = ack_q;

endmodule

// File: tb/tb_addsub_fu.sv
// Directed bench for addsub_fu (16-bit lanes, 4 lanes) with a queue of expected results.
module tb_addsub_fu;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  cy;
        logic [3:0]  ov;
        logic        err;
        logic [3:0]  dest;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               on_off;
    logic [7:0][15:0]   in_v;
    logic [15:0]        cfg;
    logic [3:0][15:0]   outputs;
    logic [3:0]         dest_info, carry_out, overflow;
    logic               cfg_err, ack;

    int   vectors = 0;
    int   miscompares = 0;
    int   cnt;
    exp_t sb[$];

    addsub_fu #(.width(16), .num_lanes(4), .cfg_width(16)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .on_off    (on_off),
        .inputs    (in_v),
        .config_in (cfg),
        .outputs   (outputs),
        .dest_info (dest_info),
        .carry_out (carry_out),
        .overflow  (overflow),
        .cfg_err   (cfg_err),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0][15:0] pk(input logic [15:0] a0, b0, a1, b1, a2, b2, a3, b3);
        return {b3, a3, b2, a2, b1, a1, b0, a0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack !== 1'b1 && n < 20);
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        vectors++;
        assert (sb.size() > 0) else begin
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".res"},  outputs,   e.res);
            check({tag, ".cy"},   carry_out, e.cy);
            check({tag, ".ov"},   overflow,  e.ov);
            check({tag, ".err"},  cfg_err,   e.err);
            check({tag, ".dest"}, dest_info, e.dest);
        end
    endtask

    // Caller is positioned just after a falling edge with the FSM in IDLE.
    task automatic run_op(input string tag, input logic [7:0][15:0] ins, input logic [15:0] c,
                          input exp_t e, input int hold);
        sb.push_back(e);
        in_v   = ins;
        cfg    = c;
        on_off = 1'b1;
        wait_ack(cnt);
        check({tag, ".latency"}, cnt, 3);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".ack_hold"}, ack, 1'b1);
        end
        compare_result(tag);
        on_off = 1'b0;
        in_v   = {8{16'hDEAD}};
        cfg    = 16'hFFFF;
        @(negedge clk);
        check({tag, ".ack_drop"}, ack, 1'b0);
        check({tag, ".res_keep"}, outputs, e.res);
    endtask

    initial begin
        rst_n  = 1'b0;
        on_off = 1'b0;
        in_v   = '0;
        cfg    = '0;
        repeat (3) @(negedge clk);
        check("rst.res",  outputs,   64'h0);
        check("rst.ack",  ack,       1'b0);
        check("rst.flag", {carry_out, overflow, cfg_err, dest_info}, 13'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("lane_add", pk(16'h0001, 16'h0002, 16'h0003, 16'h0004,
                              16'hFFFF, 16'h0001, 16'h7FFF, 16'h0001), 16'h0000,
               '{res: 64'h8000_0000_0007_0003, cy: 4'b0100, ov: 4'b1000, err: 1'b0, dest: 4'h0}, 3);

        run_op("two_lane", pk(16'hFFFF, 16'h0001, 16'h0000, 16'h0000,
                              16'hFFFF, 16'h0001, 16'h7FFF, 16'h0000), 16'h0001,
               '{res: 64'h8000_0000_0001_0000, cy: 4'b0000, ov: 4'b1000, err: 1'b0, dest: 4'h0}, 0);

        run_op("full_sub", pk(16'h0000, 16'h0001, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'hA5D7,
               '{res: 64'hFFFF_FFFF_FFFF_FFFF, cy: 4'b0000, ov: 4'b0000, err: 1'b0, dest: 4'hD}, 0);

        run_op("sat_lane", pk(16'h7FFF, 16'hFFFF, 16'h8000, 16'h0001,
                              16'h0005, 16'h0003, 16'h0000, 16'h0000), 16'h000C,
               '{res: 64'h0000_0002_8000_7FFF, cy: 4'b1110, ov: 4'b0011, err: 1'b0, dest: 4'h0}, 0);

        run_op("sat_seg", pk(16'hFFFF, 16'h0001, 16'h7FFF, 16'h0000,
                             16'h0000, 16'h0000, 16'h8000, 16'h8000), 16'h0009,
               '{res: 64'h8000_0000_7FFF_FFFF, cy: 4'b1000, ov: 4'b1010, err: 1'b0, dest: 4'h0}, 0);

        run_op("illegal", pk(16'h0001, 16'h0002, 16'h0003, 16'h0004,
                             16'h0005, 16'h0006, 16'h0007, 16'h0008), 16'h0022,
               '{res: 64'h0, cy: 4'b0000, ov: 4'b0000, err: 1'b1, dest: 4'h2}, 1);

        // Reset lands while the FSM is in EXEC; the operation must vanish.
        in_v   = pk(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hFFFF, 16'h0001, 16'h7FFF, 16'h0001);
        cfg    = 16'h0000;
        on_off = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_exec.res",  outputs, 64'h0);
        check("rst_exec.ack",  ack,     1'b0);
        check("rst_exec.flag", {carry_out, overflow, cfg_err, dest_info}, 13'h0);
        repeat (4) @(negedge clk);
        check("rst_exec.ack_held", ack, 1'b0);

        // Release reset with on_off still high: a fresh operation starts at once.
        sb.push_back('{res: 64'h0000_0002_8000_7FFF, cy: 4'b1110, ov: 4'b0011, err: 1'b0, dest: 4'h0});
        in_v  = pk(16'h7FFF, 16'hFFFF, 16'h8000, 16'h0001, 16'h0005, 16'h0003, 16'h0000, 16'h0000);
        cfg   = 16'h000C;
        rst_n = 1'b1;
        wait_ack(cnt);
        check("restart.latency", cnt, 3);
        compare_result("restart");
        on_off = 1'b0;
        @(negedge clk);
        check("restart.ack_drop", ack, 1'b0);

        // on_off drops in EXEC and operands change after the latch edge.
        sb.push_back('{res: 64'h8000_0000_0001_0000, cy: 4'b0000, ov: 4'b1000, err: 1'b0, dest: 4'h6});
        in_v   = pk(16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'h7FFF, 16'h0000);
        cfg    = 16'h0061;
        on_off = 1'b1;
        @(negedge clk);
        on_off = 1'b0;
        in_v   = {8{16'h1234}};
        cfg    = 16'h000B;
        cnt    = 1;
        while (ack !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("pulse.latency", cnt, 3);
        compare_result("pulse");
        @(negedge clk);
        check("pulse.ack_single", ack, 1'b0);
        repeat (3) @(negedge clk);
        check("pulse.no_retrigger", ack, 1'b0);
        check("pulse.sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
